// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single-port SoC RAM bus: serialises whole
// transactions (IDLE -> ISSUE -> ACK) and returns a one-cycle ack plus read data.
module mem_bus_arbiter #(
    parameter int RR     = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wmask,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wmask,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rstrb,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              grant;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wmask_q;
    logic              eff_req0;
    logic              eff_req1;
    logic              arb;
    logic              win;

    // The master acked this cycle is masked so a held req is not replayed.
    always_comb begin
        state_next = state;
        arb        = 1'b0;
        win        = 1'b0;
        eff_req0   = m0_req & ~m0_ack;
        eff_req1   = m1_req & ~m1_ack;
        case (state)
            IDLE: begin
                if (eff_req0 | eff_req1) begin
                    arb        = 1'b1;
                    state_next = ISSUE;
                    if (eff_req0 & eff_req1)
                        win = (RR != 0) ? ~last_grant : 1'b0;
                    else
                        win = eff_req1;
                end
            end
            ISSUE:   state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            state  <= state_next;
            m0_ack <= (state == ACK) && !grant;
            m1_ack <= (state == ACK) && grant;
            if (arb) begin
                grant      <= win;
                last_grant <= win;
                addr_q     <= win ? m1_addr  : m0_addr;
                wdata_q    <= win ? m1_wdata : m0_wdata;
                wmask_q    <= win ? m1_wmask : m0_wmask;
            end
            if (state == ACK && wmask_q == 4'b0000) begin
                if (grant)
                    m1_rdata <= mem_rdata;
                else
                    m0_rdata <= mem_rdata;
            end
        end
    end

    // Address/data hold their last registered value; strobes only fire in ISSUE.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rstrb = (state == ISSUE) && (wmask_q == 4'b0000);
    assign mem_wmask = (state == ISSUE) ? wmask_q : 4'b0000;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench: instance a (round-robin) with a small RAM model,
// instance b (fixed priority) with a RAM that returns the inverted address.
module tb_mem_bus_arbiter;

    logic clk;
    int   checks = 0;
    int   passes = 0;

    logic        a_rst, a_m0_req, a_m1_req, a_m0_ack, a_m1_ack;
    logic [31:0] a_m0_addr, a_m0_wdata, a_m0_rdata, a_m1_addr, a_m1_wdata, a_m1_rdata;
    logic [3:0]  a_m0_wmask, a_m1_wmask, a_mem_wmask;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_rstrb, a_busy;

    logic        b_rst, b_m0_req, b_m1_req, b_m0_ack, b_m1_ack;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata, b_m1_addr, b_m1_wdata, b_m1_rdata;
    logic [3:0]  b_m0_wmask, b_m1_wmask, b_mem_wmask;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_rstrb, b_busy;

    logic [31:0] ram [16];

    mem_bus_arbiter #(.RR(1), .ADDR_W(32)) u_rr (
        .clk(clk), .reset(a_rst),
        .m0_req(a_m0_req), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata), .m0_wmask(a_m0_wmask),
        .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata), .m1_wmask(a_m1_wmask),
        .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
        .mem_addr(a_mem_addr), .mem_rstrb(a_mem_rstrb), .mem_wmask(a_mem_wmask),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_bus_arbiter #(.RR(0), .ADDR_W(32)) u_fp (
        .clk(clk), .reset(b_rst),
        .m0_req(b_m0_req), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_wmask(b_m0_wmask),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_wmask(b_m1_wmask),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .mem_addr(b_mem_addr), .mem_rstrb(b_mem_rstrb), .mem_wmask(b_mem_wmask),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM for instance a: word 4 preloaded with 0xDEADBEEF on every reset.
    always @(posedge clk) begin
        if (a_rst) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
            ram[4] <= 32'hDEADBEEF;
        end else begin
            if (a_mem_rstrb) a_mem_rdata <= ram[a_mem_addr[5:2]];
            for (int b = 0; b < 4; b++)
                if (a_mem_wmask[b]) ram[a_mem_addr[5:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (b_mem_rstrb) b_mem_rdata <= ~b_mem_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Single transaction on instance a, entered at a negedge while IDLE.
    task automatic txn(input bit m, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm, input logic [31:0] exp_rd, input string tag);
        if (!m) begin
            a_m0_req = 1'b1; a_m0_addr = addr; a_m0_wdata = wd; a_m0_wmask = wm;
        end else begin
            a_m1_req = 1'b1; a_m1_addr = addr; a_m1_wdata = wd; a_m1_wmask = wm;
        end
        @(negedge clk);
        check({tag, "_issue_rstrb"}, 32'(a_mem_rstrb), 32'(wm == 4'b0000));
        check({tag, "_issue_wmask"}, 32'(a_mem_wmask), 32'(wm));
        check({tag, "_issue_addr"}, a_mem_addr, addr);
        if (wm != 4'b0000) check({tag, "_issue_wdata"}, a_mem_wdata, wd);
        @(negedge clk);
        check({tag, "_ackst_strobes"}, {27'h0, a_mem_rstrb, a_mem_wmask}, 32'h0);
        check({tag, "_ackst_noack"}, {30'h0, a_m1_ack, a_m0_ack}, 32'h0);
        @(negedge clk);
        check({tag, "_ack"}, {30'h0, a_m1_ack, a_m0_ack}, m ? 32'h2 : 32'h1);
        if (wm == 4'b0000) check({tag, "_rdata"}, m ? a_m1_rdata : a_m0_rdata, exp_rd);
        if (!m) a_m0_req = 1'b0; else a_m1_req = 1'b0;
    endtask

    logic [6:0]  rh, ah;
    logic [11:0] h0, h1;
    logic [5:0]  f0, f1;
    int          both;
    logic        any_ack;

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_m0_req = 0; a_m1_req = 0; b_m0_req = 0; b_m1_req = 0;
        a_m0_addr = '0; a_m0_wdata = '0; a_m0_wmask = '0;
        a_m1_addr = '0; a_m1_wdata = '0; a_m1_wmask = '0;
        b_m0_addr = '0; b_m0_wdata = '0; b_m0_wmask = '0;
        b_m1_addr = '0; b_m1_wdata = '0; b_m1_wmask = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(a_busy), 32'h0);
        check("rst_strobes", {27'h0, a_mem_rstrb, a_mem_wmask}, 32'h0);
        check("rst_addr", a_mem_addr, 32'h0);
        check("rst_wdata", a_mem_wdata, 32'h0);
        check("rst_acks", {30'h0, a_m1_ack, a_m0_ack}, 32'h0);
        check("rst_rdata", a_m0_rdata | a_m1_rdata, 32'h0);
        a_rst = 1'b0; b_rst = 1'b0;

        txn(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, "m0_rd10");
        txn(1'b1, 32'h20, 32'h12345678, 4'b0011, 32'h0, "m1_wr20");
        check("m0_rdata_held", a_m0_rdata, 32'hDEADBEEF);
        txn(1'b0, 32'h20, 32'h0, 4'b0000, 32'h00005678, "m0_rd20");

        // m0 holds req across its ack: issues at t+1 and t+5, acks at t+3 and t+7.
        @(negedge clk);
        a_m0_req = 1'b1; a_m0_addr = 32'h10; a_m0_wmask = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rh[i] = a_mem_rstrb;
            ah[i] = a_m0_ack;
        end
        a_m0_req = 1'b0;
        check("hold_rstrb_hist", 32'(rh), 32'h11);
        check("hold_ack_hist", 32'(ah), 32'h44);
        @(negedge clk);
        check("hold_idle_after", 32'(a_busy), 32'h0);

        // Both masters requesting continuously from reset: m0 first, then alternate.
        a_rst = 1'b1;
        a_m0_req = 1'b1; a_m0_addr = 32'h20; a_m0_wmask = 4'b0000;
        a_m1_req = 1'b1; a_m1_addr = 32'h10; a_m1_wmask = 4'b0000;
        @(negedge clk);
        a_rst = 1'b0;
        both = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            h0[i] = a_m0_ack;
            h1[i] = a_m1_ack;
            if (a_m0_ack && a_m1_ack) both++;
        end
        a_m0_req = 1'b0; a_m1_req = 1'b0;
        check("rr_m0_ack_hist", 32'(h0), 32'h104);
        check("rr_m1_ack_hist", 32'(h1), 32'h820);
        check("rr_no_double_ack", both, 32'h0);
        check("rr_m1_rdata", a_m1_rdata, 32'hDEADBEEF);

        // Reset during ISSUE of an m1 read aborts it with no ack.
        @(negedge clk);
        check("abort_idle_before", 32'(a_busy), 32'h0);
        a_m1_req = 1'b1; a_m1_addr = 32'h10; a_m1_wmask = 4'b0000;
        @(negedge clk);
        check("abort_in_issue", 32'(a_mem_rstrb), 32'h1);
        a_rst = 1'b1; a_m1_req = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(a_busy), 32'h0);
        check("abort_strobes", {27'h0, a_mem_rstrb, a_mem_wmask}, 32'h0);
        check("abort_addr_wdata", a_mem_addr | a_mem_wdata, 32'h0);
        check("abort_rdata", a_m0_rdata | a_m1_rdata, 32'h0);
        a_rst = 1'b0;
        any_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            any_ack = any_ack | a_m0_ack | a_m1_ack;
        end
        check("abort_no_ack", 32'(any_ack), 32'h0);
        txn(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, "post_rst_rd");

        // Fixed priority: after an m0 grant, a tie still goes to m0; m1 follows once m0 drops.
        b_m0_req = 1'b1; b_m0_addr = 32'h10; b_m0_wmask = 4'b0000;
        repeat (3) @(negedge clk);
        check("fp_first_ack", {30'h0, b_m1_ack, b_m0_ack}, 32'h1);
        check("fp_first_rdata", b_m0_rdata, 32'hFFFFFFEF);
        b_m0_req = 1'b0;
        @(negedge clk);
        b_m0_req = 1'b1;
        b_m1_req = 1'b1; b_m1_addr = 32'h44; b_m1_wmask = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            f0[i] = b_m0_ack;
            f1[i] = b_m1_ack;
            if (i == 2) b_m0_req = 1'b0;
        end
        b_m1_req = 1'b0;
        check("fp_m0_ack_hist", 32'(f0), 32'h04);
        check("fp_m1_ack_hist", 32'(f1), 32'h20);
        check("fp_m1_rdata", b_m1_rdata, 32'hFFFFFFBB);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
